// File: rtl/branch_resolver_bht.sv
// Branch direction predictor and mispredict resolver: a direct-mapped table of
// saturating counters, a registered flush/redirect pulse and saturating perf counters.
module branch_resolver_bht #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 6,
    parameter int CNT_W = 2,
    parameter int CTR_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_is_branch,
    input  logic             res_is_jump,
    input  logic [XLEN-1:0]  res_pc,
    input  logic             res_pred_taken,
    input  logic             res_taken,
    input  logic [XLEN-1:0]  res_target,
    output logic             wrong,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CTR_W-1:0] branch_count,
    output logic [CTR_W-1:0] mispredict_count
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [CNT_W-1:0] WNT = CNT_W'((1 << (CNT_W - 1)) - 1);

    logic [CNT_W-1:0] tbl_q [DEPTH];
    logic             wrong_q, wrong_d;
    logic [XLEN-1:0]  redir_q, redir_d;
    logic [CTR_W-1:0] bcnt_q, bcnt_d, mcnt_q, mcnt_d;

    logic [IDX_W-1:0] fidx, ridx;
    logic             accept, act, mispred, train;
    logic [CNT_W-1:0] cnt_cur, cnt_d;

    assign fidx = if_pc[IDX_W+1:2];
    assign ridx = res_pc[IDX_W+1:2];

    // No bypass: a lookup colliding with a same-cycle update sees the old value.
    assign pred_taken = tbl_q[fidx][CNT_W-1];

    // Resolves arriving while a flush is pending are on the squashed path.
    assign accept  = res_valid & ~wrong_q & (res_is_branch | res_is_jump);
    assign act     = res_is_jump ? 1'b1 : res_taken;
    assign mispred = accept & (act != res_pred_taken);
    assign train   = accept & res_is_branch & ~res_is_jump;
    assign cnt_cur = tbl_q[ridx];

    always_comb begin
        cnt_d = cnt_cur;
        if (act && cnt_cur != {CNT_W{1'b1}})
            cnt_d = cnt_cur + CNT_W'(1);
        else if (!act && cnt_cur != '0)
            cnt_d = cnt_cur - CNT_W'(1);
    end

    always_comb begin
        wrong_d = mispred;
        redir_d = redir_q;
        bcnt_d  = bcnt_q;
        mcnt_d  = mcnt_q;
        if (mispred)
            redir_d = act ? res_target : res_pc + XLEN'(4);
        if (accept && bcnt_q != {CTR_W{1'b1}})
            bcnt_d = bcnt_q + CTR_W'(1);
        if (mispred && mcnt_q != {CTR_W{1'b1}})
            mcnt_d = mcnt_q + CTR_W'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrong_q <= 1'b0;
            redir_q <= '0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            wrong_q <= wrong_d;
            redir_q <= redir_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++)
                tbl_q[i] <= WNT;
        end else if (train) begin
            tbl_q[ridx] <= cnt_d;
        end
    end

    assign wrong            = wrong_q;
    assign redirect_pc      = redir_q;
    assign branch_count     = bcnt_q;
    assign mispredict_count = mcnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

endmodule

// File: tb/tb_branch_resolver_bht.sv
// Directed-vector bench for branch_resolver_bht (counter width 2 to reach saturation quickly).
module tb_branch_resolver_bht;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic        res_valid, res_is_branch, res_is_jump, res_pred_taken, res_taken;
    logic [31:0] res_pc, res_target;
    logic        wrong;
    logic [31:0] redirect_pc;
    logic [1:0]  branch_count, mispredict_count;

    int nvec = 0;
    int nmis = 0;

    logic        pre_pred, w1;
    logic [31:0] rp1;

    branch_resolver_bht #(.XLEN(32), .IDX_W(6), .CNT_W(2), .CTR_W(2)) dut (
        .CLK(CLK), .RST(RST), .if_pc(if_pc), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_is_branch(res_is_branch), .res_is_jump(res_is_jump),
        .res_pc(res_pc), .res_pred_taken(res_pred_taken), .res_taken(res_taken),
        .res_target(res_target), .wrong(wrong), .redirect_pc(redirect_pc),
        .branch_count(branch_count), .mispredict_count(mispredict_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic br, input logic jp, input logic [31:0] pc,
                         input logic pp, input logic tk, input logic [31:0] tgt);
        res_valid      = 1'b1;
        res_is_branch  = br;
        res_is_jump    = jp;
        res_pc         = pc;
        res_pred_taken = pp;
        res_taken      = tk;
        res_target     = tgt;
    endtask

    task automatic idle_in();
        res_valid = 1'b0; res_is_branch = 1'b0; res_is_jump = 1'b0;
        res_pc = '0; res_pred_taken = 1'b0; res_taken = 1'b0; res_target = '0;
    endtask

    // One resolve cycle followed by one idle cycle; captures the pulse and pre-edge prediction.
    task automatic resolve(input logic br, input logic jp, input logic [31:0] pc,
                           input logic pp, input logic tk, input logic [31:0] tgt);
        drive(br, jp, pc, pp, tk, tgt);
        #1;
        pre_pred = pred_taken;
        @(posedge CLK);
        #1;
        w1  = wrong;
        rp1 = redirect_pc;
        idle_in();
        step();
    endtask

    initial begin
        RST = 1'b1;
        if_pc = 32'h40;
        idle_in();
        step();
        step();
        chk("rst_wrong", 32'(wrong), 0);
        chk("rst_redir", redirect_pc, 0);
        chk("rst_bcnt", 32'(branch_count), 0);
        chk("rst_mcnt", 32'(mispredict_count), 0);
        RST = 1'b0;
        step();
        chk("pred_40_init", 32'(pred_taken), 0);

        // Mispredicted taken branch at 0x40 (entry 01 -> 10)
        resolve(1, 0, 32'h40, 0, 1, 32'h100);
        chk("nobypass", 32'(pre_pred), 0);
        chk("mp1_wrong", 32'(w1), 1);
        chk("mp1_redir", rp1, 32'h100);
        chk("mp1_wrong_drop", 32'(wrong), 0);
        chk("mp1_mcnt", 32'(mispredict_count), 1);
        chk("mp1_bcnt", 32'(branch_count), 1);
        chk("pred_40_10", 32'(pred_taken), 1);

        // Three correct taken resolves: 11, 11 (saturated), branch_count saturates at 3
        resolve(1, 0, 32'h40, 1, 1, 32'h100);
        chk("tk2_wrong", 32'(w1), 0);
        resolve(1, 0, 32'h40, 1, 1, 32'h100);
        resolve(1, 0, 32'h40, 1, 1, 32'h100);
        chk("bcnt_sat", 32'(branch_count), 3);
        chk("tk_mcnt", 32'(mispredict_count), 1);

        // Not taken from 11 -> 10 still taken; again -> 01 not taken
        resolve(1, 0, 32'h40, 1, 0, 32'h100);
        chk("nt1_wrong", 32'(w1), 1);
        chk("nt1_redir", rp1, 32'h44);
        chk("nt1_pred", 32'(pred_taken), 1);
        chk("nt1_mcnt", 32'(mispredict_count), 2);
        resolve(1, 0, 32'h40, 1, 0, 32'h100);
        chk("nt2_pred", 32'(pred_taken), 0);
        chk("nt2_mcnt", 32'(mispredict_count), 3);
        resolve(1, 0, 32'h40, 1, 0, 32'h100);
        resolve(1, 0, 32'h40, 1, 0, 32'h100);
        chk("mcnt_sat", 32'(mispredict_count), 3);
        chk("nt4_redir", rp1, 32'h44);

        // Train 0x80 up to 11, then reset during a pending flush
        if_pc = 32'h80;
        resolve(1, 0, 32'h80, 0, 1, 32'h180);
        resolve(1, 0, 32'h80, 1, 1, 32'h180);
        chk("pred_80", 32'(pred_taken), 1);
        drive(1, 0, 32'h80, 0, 0, 32'h180);
        res_pred_taken = 1'b1;
        step();
        chk("pre_rst_wrong", 32'(wrong), 1);
        idle_in();
        RST = 1'b1;
        #1;
        chk("mrst_wrong", 32'(wrong), 0);
        chk("mrst_redir", redirect_pc, 0);
        chk("mrst_bcnt", 32'(branch_count), 0);
        chk("mrst_mcnt", 32'(mispredict_count), 0);
        chk("mrst_pred_80", 32'(pred_taken), 0);
        step();
        RST = 1'b0;
        step();
        chk("post_rst_wrong", 32'(wrong), 0);

        // JAL at 0x200 (index 0) mispredicted; follow-up resolve in shadow is ignored
        if_pc = 32'h200;
        drive(0, 1, 32'h200, 0, 0, 32'h300);
        step();
        chk("jal_wrong", 32'(wrong), 1);
        chk("jal_redir", redirect_pc, 32'h300);
        drive(1, 0, 32'h0, 0, 1, 32'h500);
        step();
        chk("shadow_wrong", 32'(wrong), 0);
        chk("shadow_redir", redirect_pc, 32'h300);
        chk("shadow_mcnt", 32'(mispredict_count), 1);
        chk("shadow_bcnt", 32'(branch_count), 1);
        chk("jal_notrain", 32'(pred_taken), 0);
        idle_in();
        step();

        // Both flags set: jump wins (taken, target), no training
        resolve(1, 1, 32'h200, 0, 0, 32'h340);
        chk("both_wrong", 32'(w1), 1);
        chk("both_redir", rp1, 32'h340);
        chk("both_notrain", 32'(pred_taken), 0);
        chk("both_mcnt", 32'(mispredict_count), 2);

        // Neither flag set: ignored
        resolve(0, 0, 32'h40, 1, 0, 32'h340);
        chk("none_wrong", 32'(w1), 0);
        chk("none_bcnt", 32'(branch_count), 2);

        // Aliasing: training 0x100 changes prediction seen at 0x0
        if_pc = 32'h0;
        chk("alias_pre", 32'(pred_taken), 0);
        resolve(1, 0, 32'h100, 0, 1, 32'h400);
        chk("alias_redir", rp1, 32'h400);
        chk("alias_post", 32'(pred_taken), 1);
        chk("alias_bcnt", 32'(branch_count), 3);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
